// File: rtl/fht_unload.sv
// fht_unload: streams a finished FHT result out of the four fht_top RAM
// banks. Rows are read in bit-reversed address order, so the stream comes out
// in natural order. Each row is sent as bank 0..3, one word per handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for iSTART while iFHT_RDY is high
// FETCH | first row address on the bus, waiting RD_LAT cycles for data
// SEND  | streaming the row buffer; the next row is prefetched meanwhile
// DONE  | one-cycle completion pulse on oDONE
//
// The prefetch is safe only up to RD_LAT = 3. With that latency the next row
// is captured no later than the cycle of the current row's last transfer.
module fht_unload #(
    parameter int D_BIT  = 22,
    parameter int A_BIT  = 8,
    parameter int RD_LAT = 2
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    input  logic             iFHT_RDY,
    output logic [A_BIT-1:0] oADDR_RD_0,
    output logic [A_BIT-1:0] oADDR_RD_1,
    output logic [A_BIT-1:0] oADDR_RD_2,
    output logic [A_BIT-1:0] oADDR_RD_3,
    input  logic [D_BIT-1:0] iDATA_0,
    input  logic [D_BIT-1:0] iDATA_1,
    input  logic [D_BIT-1:0] iDATA_2,
    input  logic [D_BIT-1:0] iDATA_3,
    output logic [D_BIT-1:0] oDATA,
    output logic             oVALID,
    input  logic             iREADY,
    output logic             oLAST,
    output logic             oBUSY,
    output logic             oDONE
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [A_BIT-1:0] ROW_MAX = '1;
    localparam logic [1:0]       LAT     = 2'(RD_LAT);

    state_t           state;
    state_t           state_next;

    logic [A_BIT-1:0] addr_cnt;   // row index currently on the read address bus
    logic [A_BIT-1:0] cur_row;    // row index held in the row buffer
    logic [1:0]       word_cnt;   // bank index of the word being offered
    logic [1:0]       lat_cnt;    // FETCH wait, counts down to capture
    logic [1:0]       pf_cnt;     // prefetch wait, counts down to capture
    logic             pf_pend;
    logic             pf_valid;

    logic [D_BIT-1:0] rd_data [4];
    logic [D_BIT-1:0] row_buf [4];
    logic [D_BIT-1:0] pf_buf  [4];

    logic             accept;
    logic             fetch_cap;
    logic             pf_cap;
    logic             xfer;
    logic             row_end;
    logic             final_row;
    logic             pf_more;
    logic [A_BIT-1:0] addr_rev;

    function automatic logic [A_BIT-1:0] bitrev(input logic [A_BIT-1:0] v);
        logic [A_BIT-1:0] r;
        for (int i = 0; i < A_BIT; i++) begin
            r[i] = v[A_BIT-1-i];
        end
        return r;
    endfunction

    assign rd_data[0] = iDATA_0;
    assign rd_data[1] = iDATA_1;
    assign rd_data[2] = iDATA_2;
    assign rd_data[3] = iDATA_3;

    assign addr_rev   = bitrev(addr_cnt);
    assign oADDR_RD_0 = addr_rev;
    assign oADDR_RD_1 = addr_rev;
    assign oADDR_RD_2 = addr_rev;
    assign oADDR_RD_3 = addr_rev;

    // State register.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, handshake decode and status outputs.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        fetch_cap  = 1'b0;
        xfer       = 1'b0;
        final_row  = (cur_row == ROW_MAX);
        pf_more    = (addr_cnt != ROW_MAX);
        pf_cap     = pf_pend && (pf_cnt == 2'd0);
        oVALID     = 1'b0;
        oBUSY      = 1'b1;
        oDONE      = 1'b0;
        case (state)
            IDLE: begin
                oBUSY  = 1'b0;
                accept = iSTART && iFHT_RDY;
                if (accept) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                fetch_cap = (lat_cnt == 2'd0);
                if (fetch_cap) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                oVALID = 1'b1;
                xfer   = iREADY;
                if (xfer && (word_cnt == 2'd3) && final_row) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                oDONE      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        row_end = xfer && (word_cnt == 2'd3);
        oLAST   = oVALID && final_row && (word_cnt == 2'd3);
    end

    // Word select out of the row buffer.
    always_comb begin
        oDATA = row_buf[word_cnt];
    end

    // Address counter, latency timers, row and prefetch buffers.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            addr_cnt <= '0;
            cur_row  <= '0;
            word_cnt <= 2'd0;
            lat_cnt  <= 2'd0;
            pf_cnt   <= 2'd0;
            pf_pend  <= 1'b0;
            pf_valid <= 1'b0;
            for (int b = 0; b < 4; b++) begin
                row_buf[b] <= '0;
                pf_buf[b]  <= '0;
            end
        end else begin
            if (accept) begin
                addr_cnt <= '0;
                cur_row  <= '0;
                word_cnt <= 2'd0;
                lat_cnt  <= LAT;
                pf_cnt   <= 2'd0;
                pf_pend  <= 1'b0;
                pf_valid <= 1'b0;
            end

            if ((state == FETCH) && (lat_cnt != 2'd0)) begin
                lat_cnt <= lat_cnt - 2'd1;
            end

            if (pf_pend && (pf_cnt != 2'd0)) begin
                pf_cnt <= pf_cnt - 2'd1;
            end

            if (pf_cap) begin
                pf_buf   <= rd_data;
                pf_valid <= 1'b1;
                pf_pend  <= 1'b0;
            end

            if (fetch_cap) begin
                row_buf  <= rd_data;
                word_cnt <= 2'd0;
                cur_row  <= addr_cnt;
                if (pf_more) begin
                    addr_cnt <= addr_cnt + 1'b1;
                    pf_pend  <= 1'b1;
                    pf_cnt   <= LAT;
                end
            end

            if (xfer) begin
                word_cnt <= word_cnt + 2'd1;
            end

            // Row hand-over; placed after the capture so these assignments win
            // when the prefetch lands in the same cycle and goes straight in.
            if (row_end && !final_row) begin
                if (pf_valid) begin
                    row_buf <= pf_buf;
                end else begin
                    row_buf <= rd_data;
                end
                pf_valid <= 1'b0;
                cur_row  <= addr_cnt;
                if (pf_more) begin
                    addr_cnt <= addr_cnt + 1'b1;
                    pf_pend  <= 1'b1;
                    pf_cnt   <= LAT;
                end
            end
        end
    end

endmodule
